// File: rtl/seq_enc_param_pkg.sv
// Shared state encoding and counter width helper for the sequence encoder.
package seq_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_enc_param_if.sv
// Trigger/status bundle between control logic and the sequence encoder.
interface seq_enc_param_if;

  logic flag;
  logic repeat_en;
  logic sm_out;
  logic busy;
  logic done;

  modport master (
    output flag,
    output repeat_en,
    input  sm_out,
    input  busy,
    input  done
  );

  modport slave (
    input  flag,
    input  repeat_en,
    output sm_out,
    output busy,
    output done
  );

endinterface

// File: rtl/seq_enc_param.sv
// Serialises a constant LEN-bit pattern MSB-first on a flag rising edge, with
// optional repeat mode separated by GAP idle cycles.
module seq_enc_param
  import seq_enc_pkg::*;
#(
  parameter int unsigned     LEN      = 8,
  parameter logic [LEN-1:0]  PATTERN  = 8'b1011_0010,
  parameter logic            IDLE_VAL = 1'b0,
  parameter int unsigned     GAP      = 2
) (
  input  logic           clk,
  input  logic           reset,
  seq_enc_param_if.slave bus
);

  localparam int unsigned CW = cnt_width(LEN);
  localparam int unsigned GW = cnt_width(GAP + 1);

  localparam logic [CW-1:0] CntLast  = CW'(LEN - 1);
  localparam logic [CW-1:0] CntFirst = CW'(LEN - 2);
  // Guarded so GAP=0 does not produce a negative reload value.
  localparam logic [GW-1:0] GapInit  = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          flag_q;
  logic          sm_out_q, sm_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          trigger;
  logic          rearm;

  assign trigger = bus.flag & ~flag_q;
  assign rearm   = bus.repeat_en & bus.flag;

  // State, counters, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CntLast;
      gap_q    <= '0;
      flag_q   <= 1'b0;
      sm_out_q <= IDLE_VAL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      flag_q   <= bus.flag;
      sm_out_q <= sm_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; done_q marks the last-bit cycle of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (done_q) begin
          if (rearm) state_d = (GAP > 0) ? ST_GAP : ST_SEND;
          else       state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sm_out_d = sm_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          sm_out_d = PATTERN[LEN-1];
          busy_d   = 1'b1;
          cnt_d    = CntFirst;
        end else begin
          sm_out_d = IDLE_VAL;
          busy_d   = 1'b0;
        end
      end
      ST_SEND: begin
        if (done_q) begin
          if (rearm && (GAP > 0)) begin
            sm_out_d = IDLE_VAL;
            busy_d   = 1'b1;
            gap_d    = GapInit;
          end else if (rearm) begin
            // Back-to-back frame: MSB follows the LSB with no idle cycle.
            sm_out_d = PATTERN[LEN-1];
            busy_d   = 1'b1;
            cnt_d    = CntFirst;
          end else begin
            sm_out_d = IDLE_VAL;
            busy_d   = 1'b0;
          end
        end else begin
          sm_out_d = PATTERN[cnt_q];
          busy_d   = 1'b1;
          done_d   = (cnt_q == '0);
          // Counter parks at LEN-1 once bit 0 is issued instead of wrapping.
          cnt_d    = (cnt_q == '0) ? CntLast : cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          sm_out_d = PATTERN[LEN-1];
          cnt_d    = CntFirst;
        end else begin
          sm_out_d = IDLE_VAL;
          gap_d    = gap_q - GW'(1);
        end
      end
      default: begin
        sm_out_d = IDLE_VAL;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign bus.sm_out = sm_out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_enc_param.sv
// Directed bench for seq_enc_param: default 8-bit config plus a 4-bit
// back-to-back config with IDLE_VAL=1.
module tb_seq_enc_param;

  localparam logic [7:0] PAT_A = 8'b1011_0010;
  localparam logic [3:0] PAT_B = 4'b1001;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   done_cnt;

  seq_enc_param_if ia ();
  seq_enc_param_if ib ();

  seq_enc_param dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  seq_enc_param #(
    .LEN      (4),
    .PATTERN  (4'b1001),
    .IDLE_VAL (1'b1),
    .GAP      (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frames completed on dut_a, counted by done pulses.
  always @(posedge clk) begin
    if (ia.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, " sm_out"}, ia.sm_out, 1'b0);
    check({tag, " busy"}, ia.busy, 1'b0);
    check({tag, " done"}, ia.done, 1'b0);
  endtask

  // Checks n cycles of a dut_a frame starting at the MSB cycle; flag_v[i] is
  // driven before the edge that ends cycle i.
  task automatic frame_a(input string tag, input logic [7:0] flag_v, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s sm_out[%0d]", tag, i), ia.sm_out, PAT_A[7-i]);
      check($sformatf("%s busy[%0d]", tag, i), ia.busy, 1'b1);
      check($sformatf("%s done[%0d]", tag, i), ia.done, (i == 7));
      ia.flag = flag_v[i];
      tick();
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    done_cnt     = 0;
    reset        = 1'b1;
    ia.flag      = 1'b0;
    ia.repeat_en = 1'b0;
    ib.flag      = 1'b0;
    ib.repeat_en = 1'b0;
    tick();
    reset = 1'b0;

    // Reset state of both configurations.
    check_idle_a("reset a");
    check("reset b sm_out", ib.sm_out, 1'b1);
    check("reset b busy", ib.busy, 1'b0);

    // 1: one-shot frame, flag high for a few cycles.
    for (int i = 0; i < 4; i++) tick();
    check_idle_a("t1 pre");
    ia.flag = 1'b1;
    tick();
    frame_a("t1", 8'b0000_0111, 8);
    check_idle_a("t1 post");
    tick();
    check_idle_a("t1 post2");

    // 2: held flag gives one frame only; re-trigger after a low period.
    ia.flag = 1'b1;
    tick();
    frame_a("t2a", 8'hFF, 8);
    for (int i = 0; i < 11; i++) begin
      check_idle_a($sformatf("t2 hold[%0d]", i));
      tick();
    end
    ia.flag = 1'b0;
    tick();
    tick();
    ia.flag = 1'b1;
    tick();
    frame_a("t2b", 8'h00, 8);
    check_idle_a("t2 post");

    // 3: repeat mode, GAP=2; flag drops inside frame 3.
    ia.repeat_en = 1'b1;
    ia.flag      = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      frame_a($sformatf("t3 f%0d", f), 8'hFF, 8);
      for (int g = 0; g < 2; g++) begin
        check($sformatf("t3 gap%0d sm_out[%0d]", f, g), ia.sm_out, 1'b0);
        check($sformatf("t3 gap%0d busy[%0d]", f, g), ia.busy, 1'b1);
        check($sformatf("t3 gap%0d done[%0d]", f, g), ia.done, 1'b0);
        tick();
      end
    end
    frame_a("t3 f2", 8'b0000_0111, 8);
    check_idle_a("t3 post");
    tick();
    check_idle_a("t3 post2");
    ia.repeat_en = 1'b0;

    // 4: LEN=4, GAP=0, IDLE_VAL=1 back-to-back frames.
    ib.repeat_en = 1'b1;
    ib.flag      = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t4 sm_out[%0d]", i), ib.sm_out, PAT_B[3-(i%4)]);
      check($sformatf("t4 busy[%0d]", i), ib.busy, 1'b1);
      check($sformatf("t4 done[%0d]", i), ib.done, ((i % 4) == 3));
      if (i == 11) ib.flag = 1'b0;
      tick();
    end
    check("t4 post sm_out", ib.sm_out, 1'b1);
    check("t4 post busy", ib.busy, 1'b0);
    check("t4 post done", ib.done, 1'b0);
    ib.repeat_en = 1'b0;

    // 5: reset during bit 3 aborts; flag held through reset re-triggers.
    ia.flag = 1'b1;
    tick();
    frame_a("t5a", 8'hFF, 4);
    check("t5 bit3 sm_out", ia.sm_out, PAT_A[3]);
    check("t5 bit3 busy", ia.busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_a("t5 reset");
    check("t5 reset b sm_out", ib.sm_out, 1'b1);
    tick();
    frame_a("t5b", 8'h00, 8);
    check_idle_a("t5 post");

    // 6: low-high flag pulse during SEND neither queues nor adds a frame.
    ia.flag = 1'b1;
    tick();
    frame_a("t6", 8'b1111_1011, 8);
    for (int i = 0; i < 3; i++) begin
      check_idle_a($sformatf("t6 post[%0d]", i));
      tick();
    end
    ia.flag = 1'b0;
    tick();
    n_checks++;
    assert (done_cnt == 8) else begin
      n_fail++;
      $error("FAIL frame count: observed %0d expected 8", done_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
